// File: rtl/ram_wr_ctrl_if.sv
// Port-A write / port-B sequencing bundle between the RAM test-path requester
// and ram_wr_ctrl. The controller takes the slave view.
interface ram_wr_ctrl_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 8
);
   logic              start;
   logic              auto;
   logic              ram_wr_en;
   logic [ADDR_W-1:0] ram_wr_addr;
   logic [DATA_W-1:0] ram_wr_data;
   logic              rd_flag;
   logic              busy;
   logic              pass_done;

   modport master (
      output start,
      output auto,
      input  ram_wr_en,
      input  ram_wr_addr,
      input  ram_wr_data,
      input  rd_flag,
      input  busy,
      input  pass_done
   );

   modport slave (
      input  start,
      input  auto,
      output ram_wr_en,
      output ram_wr_addr,
      output ram_wr_data,
      output rd_flag,
      output busy,
      output pass_done
   );
endinterface

// File: rtl/ram_wr_ctrl.sv
// Port-A controller: fills DEPTH words with (addr + pass_cnt), idles one GAP
// cycle, then raises rd_flag for DEPTH cycles so port B sweeps the RAM once.
module ram_wr_ctrl #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 64
) (
   input logic           clk,
   input logic           rst_n,
   ram_wr_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_GAP   = 2'd2,
      S_READ  = 2'd3
   } state_t;

   localparam logic [ADDR_W:0] LAST_PHASE = (ADDR_W+1)'(DEPTH - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W:0]   r_phase;
   logic [ADDR_W:0]   w_phase_nxt;
   logic [DATA_W-1:0] r_pass_cnt;
   logic [DATA_W-1:0] w_pass_cnt_nxt;

   logic              r_wr_en;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [DATA_W-1:0] r_wr_data;
   logic              r_rd_flag;
   logic              r_busy;
   logic              r_pass_done;

   logic              w_wr_en_nxt;
   logic [ADDR_W-1:0] w_wr_addr_nxt;
   logic [DATA_W-1:0] w_wr_data_nxt;
   logic              w_rd_flag_nxt;
   logic              w_busy_nxt;
   logic              w_pass_done_nxt;
   logic              w_phase_last;

   assign w_phase_last = (r_phase == LAST_PHASE);

   always_comb begin
      w_state_nxt     = r_state;
      w_phase_nxt     = r_phase;
      w_pass_cnt_nxt  = r_pass_cnt;
      w_pass_done_nxt = 1'b0;

      unique case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_state_nxt = S_WRITE;
               w_phase_nxt = '0;
            end
         end
         S_WRITE: begin
            if (w_phase_last) begin
               w_state_nxt = S_GAP;
               w_phase_nxt = '0;
            end else begin
               w_phase_nxt = r_phase + 1'b1;
            end
         end
         S_GAP: begin
            w_state_nxt = S_READ;
            w_phase_nxt = '0;
         end
         S_READ: begin
            if (w_phase_last) begin
               w_pass_cnt_nxt  = r_pass_cnt + 1'b1;
               w_pass_done_nxt = 1'b1;
               w_state_nxt     = bus.auto ? S_WRITE : S_IDLE;
               w_phase_nxt     = '0;
            end else begin
               w_phase_nxt = r_phase + 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_phase_nxt = '0;
         end
      endcase

      // Outputs are decoded from the next state so they appear registered
      // in the same cycle the state is entered.
      w_wr_en_nxt   = (w_state_nxt == S_WRITE);
      w_wr_addr_nxt = w_wr_en_nxt ? w_phase_nxt[ADDR_W-1:0] : '0;
      w_wr_data_nxt = w_wr_en_nxt ? (DATA_W'(w_wr_addr_nxt) + w_pass_cnt_nxt) : '0;
      w_rd_flag_nxt = (w_state_nxt == S_READ);
      w_busy_nxt    = (w_state_nxt != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_phase     <= '0;
         r_pass_cnt  <= '0;
         r_wr_en     <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_rd_flag   <= 1'b0;
         r_busy      <= 1'b0;
         r_pass_done <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_phase     <= w_phase_nxt;
         r_pass_cnt  <= w_pass_cnt_nxt;
         r_wr_en     <= w_wr_en_nxt;
         r_wr_addr   <= w_wr_addr_nxt;
         r_wr_data   <= w_wr_data_nxt;
         r_rd_flag   <= w_rd_flag_nxt;
         r_busy      <= w_busy_nxt;
         r_pass_done <= w_pass_done_nxt;
      end
   end

   assign bus.ram_wr_en   = r_wr_en;
   assign bus.ram_wr_addr = r_wr_addr;
   assign bus.ram_wr_data = r_wr_data;
   assign bus.rd_flag     = r_rd_flag;
   assign bus.busy        = r_busy;
   assign bus.pass_done   = r_pass_done;

endmodule

// File: tb/tb_ram_wr_ctrl.sv
// Bench for ram_wr_ctrl: per-pass timing vectors, a write/read scoreboard
// backed by a behavioural RAM and read generator, plus reset and auto runs.
module tb_ram_wr_ctrl;

   localparam int AW    = 6;
   localparam int DW    = 8;
   localparam int DEPTH = 64;
   localparam int NV    = 11;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   always #5 clk = ~clk;

   ram_wr_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   ram_wr_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      int unsigned addr;
      int unsigned data;
   } wr_t;

   typedef struct {
      int unsigned cyc;
      logic        en;
      int unsigned addr;
      logic        rd;
      logic        busy;
      logic        done;
   } vec_t;

   wr_t         wq[$];
   int unsigned rq[$];
   vec_t        tbl[NV];

   logic [DW-1:0] mem [DEPTH];
   int unsigned   rd_cnt   = 0;
   int unsigned   done_cnt = 0;
   int unsigned   exp_pcnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_evt(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got unexpected activity expected none at %0t", name, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_outs(input string tag, input logic en, input int unsigned addr,
                           input int unsigned data, input logic rd, input logic busy,
                           input logic done);
      chk({tag, "_en"},   bus.ram_wr_en,   en);
      chk({tag, "_addr"}, bus.ram_wr_addr, addr);
      chk({tag, "_data"}, bus.ram_wr_data, data);
      chk({tag, "_rd"},   bus.rd_flag,     rd);
      chk({tag, "_busy"}, bus.busy,        busy);
      chk({tag, "_done"}, bus.pass_done,   done);
   endtask

   task automatic push_pass(input int unsigned p);
      for (int unsigned a = 0; a < DEPTH; a++) begin
         wq.push_back('{addr: a, data: (a + p) % 256});
         rq.push_back((a + p) % 256);
      end
   endtask

   // Behavioural RAM and port-B read generator fed by the DUT
   always @(posedge clk) begin
      if (rst_n && bus.ram_wr_en) mem[bus.ram_wr_addr] <= bus.ram_wr_data;
   end

   wr_t         m_w;
   int unsigned m_r;

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.ram_wr_en) begin
            if (wq.size() == 0) fail_evt("unexpected_write");
            else begin
               m_w = wq.pop_front();
               chk("wr_addr", bus.ram_wr_addr, m_w.addr);
               chk("wr_data", bus.ram_wr_data, m_w.data);
            end
         end
         if (bus.rd_flag) begin
            if (rq.size() == 0) fail_evt("unexpected_read");
            else begin
               m_r = rq.pop_front();
               chk("rd_data", mem[rd_cnt % DEPTH], m_r);
            end
            rd_cnt++;
         end else begin
            rd_cnt = 0;
         end
         if (bus.pass_done) done_cnt++;
      end else begin
         rd_cnt = 0;
      end
   end

   task automatic apply_reset();
      rst_n = 1'b0;
      #1;
      chk_outs("reset", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
      wq.delete();
      rq.delete();
      exp_pcnt = 0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic run_pass(input int unsigned p, input bit busy_starts);
      int unsigned d0;
      d0 = done_cnt;
      push_pass(p);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int unsigned c = 1; c <= 131; c++) begin
         for (int i = 0; i < NV; i++) begin
            if (tbl[i].cyc == c)
               chk_outs($sformatf("pass%0d_cyc%0d", p, c), tbl[i].en, tbl[i].addr,
                        tbl[i].en ? (tbl[i].addr + p) % 256 : 0,
                        tbl[i].rd, tbl[i].busy, tbl[i].done);
         end
         bus.start = (busy_starts && (c == 10 || c == 80)) ? 1'b1 : 1'b0;
         tick();
      end
      bus.start = 1'b0;
      chk("pass_done_count", done_cnt - d0, 1);
      exp_pcnt = (p + 1) % 256;
   endtask

   initial begin
      int unsigned n, idle, badsp, last, c;

      tbl[0]  = '{cyc: 1,   en: 1'b1, addr: 0,  rd: 1'b0, busy: 1'b1, done: 1'b0};
      tbl[1]  = '{cyc: 2,   en: 1'b1, addr: 1,  rd: 1'b0, busy: 1'b1, done: 1'b0};
      tbl[2]  = '{cyc: 33,  en: 1'b1, addr: 32, rd: 1'b0, busy: 1'b1, done: 1'b0};
      tbl[3]  = '{cyc: 64,  en: 1'b1, addr: 63, rd: 1'b0, busy: 1'b1, done: 1'b0};
      tbl[4]  = '{cyc: 65,  en: 1'b0, addr: 0,  rd: 1'b0, busy: 1'b1, done: 1'b0};
      tbl[5]  = '{cyc: 66,  en: 1'b0, addr: 0,  rd: 1'b1, busy: 1'b1, done: 1'b0};
      tbl[6]  = '{cyc: 100, en: 1'b0, addr: 0,  rd: 1'b1, busy: 1'b1, done: 1'b0};
      tbl[7]  = '{cyc: 129, en: 1'b0, addr: 0,  rd: 1'b1, busy: 1'b1, done: 1'b0};
      tbl[8]  = '{cyc: 130, en: 1'b0, addr: 0,  rd: 1'b0, busy: 1'b0, done: 1'b1};
      tbl[9]  = '{cyc: 131, en: 1'b0, addr: 0,  rd: 1'b0, busy: 1'b0, done: 1'b0};
      tbl[10] = '{cyc: 120, en: 1'b0, addr: 0,  rd: 1'b1, busy: 1'b1, done: 1'b0};

      bus.start = 1'b0;
      bus.auto  = 1'b0;
      #1;
      apply_reset();

      for (int i = 0; i < 20; i++) begin
         chk("idle_busy", bus.busy, 0);
         chk("idle_wr_en", bus.ram_wr_en, 0);
         tick();
      end

      run_pass(exp_pcnt, 1'b0);
      run_pass(exp_pcnt, 1'b0);
      run_pass(exp_pcnt, 1'b1);

      // Reset while writing address 30
      push_pass(exp_pcnt);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (30) tick();
      chk("midwr_addr", bus.ram_wr_addr, 30);
      #2;
      apply_reset();
      repeat (5) tick();
      chk("post_reset_busy", bus.busy, 0);
      run_pass(exp_pcnt, 1'b0);

      // Back-to-back auto passes across the pass counter wrap
      apply_reset();
      for (int unsigned k = 0; k < 257; k++) push_pass(k % 256);
      bus.auto  = 1'b1;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      n = 0; idle = 0; badsp = 0; last = 0; c = 1;
      while (n < 257 && c < 257 * 129 + 200) begin
         if (bus.pass_done) begin
            n++;
            if (n > 1 && (c - last) != 129) badsp++;
            last = c;
            if (n == 256) bus.auto = 1'b0;
         end
         if (n < 257 && !bus.busy) idle++;
         tick();
         c++;
      end
      chk("auto_pass_count", n, 257);
      chk("auto_idle_cycles", idle, 0);
      chk("auto_period_errors", badsp, 0);
      chk("auto_last_done_cycle", last, 130 + 256 * 129);
      tick();
      chk("auto_end_busy", bus.busy, 0);

      repeat (4) tick();
      chk("wr_queue_left", wq.size(), 0);
      chk("rd_queue_left", rq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
